jelly3_img_region_multi_rect: RTL and testbench



---
 rtl/jelly3_img_region_multi_rect.sv | 244 ++++++++++++++++++++++++
 tb/tb_jelly3_img_region_multi_rect.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly3_img_region_multi_rect.sv
// ---------------------------------------------------------------------------
// jelly3_img_region_multi_rect
//
// Frame-synchronous multi-rectangle region classifier. Each incoming pixel is
// tested against up to NUM_REGIONS programmable rectangles. The pixel, its
// frame markers and the per-region hit mask come out one cke-qualified cycle
// later. Per-region hit counts are accumulated over the frame and published
// on stat_count when the frame-end pixel is accepted.
//
// Rectangle parameters are double-buffered: update_req arms a sticky pending
// flag, and the param_* inputs are copied into the shadow registers when the
// next frame-start pixel is accepted. The frame-start pixel itself is already
// classified with the new values.
//
// Ports:
//   clock, reset           clock and asynchronous active-high reset
//   cke                    clock enable; pipeline and counters hold when 0
//   update_req/update_ack  parameter update request / one-cycle latch pulse
//   param_*                per-region enable, origin and size (flattened)
//   s_*                    input frame markers, data enable, valid, pixel
//   m_*                    delayed markers and pixel, hit mask/flag/index
//   stat_valid/stat_count  one-cycle pulse with the last completed frame's
//                          per-region (saturating) hit counts
// ---------------------------------------------------------------------------
module jelly3_img_region_multi_rect #(
  parameter int                     NUM_REGIONS = 4,
  parameter int                     X_BITS      = 11,
  parameter int                     Y_BITS      = 10,
  parameter int                     DATA_BITS   = 24,
  parameter int                     COUNT_BITS  = 24,
  parameter int                     INDEX_BITS  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter logic [NUM_REGIONS-1:0] INIT_ENABLE = '0
) (
  input  logic                              reset,
  input  logic                              clock,
  input  logic                              cke,

  input  logic                              update_req,
  output logic                              update_ack,
  input  logic [NUM_REGIONS-1:0]            param_enable,
  input  logic [NUM_REGIONS*X_BITS-1:0]     param_x,
  input  logic [NUM_REGIONS*Y_BITS-1:0]     param_y,
  input  logic [NUM_REGIONS*X_BITS-1:0]     param_width,
  input  logic [NUM_REGIONS*Y_BITS-1:0]     param_height,

  input  logic                              s_row_first,
  input  logic                              s_row_last,
  input  logic                              s_col_first,
  input  logic                              s_col_last,
  input  logic                              s_de,
  input  logic                              s_valid,
  input  logic [DATA_BITS-1:0]              s_data,

  output logic                              m_row_first,
  output logic                              m_row_last,
  output logic                              m_col_first,
  output logic                              m_col_last,
  output logic                              m_de,
  output logic                              m_valid,
  output logic [DATA_BITS-1:0]              m_data,
  output logic [NUM_REGIONS-1:0]            m_mask,
  output logic                              m_hit,
  output logic [INDEX_BITS-1:0]             m_index,

  output logic                              stat_valid,
  output logic [NUM_REGIONS*COUNT_BITS-1:0] stat_count
);

  logic                              frame_start;
  logic                              frame_end;
  logic                              latch;

  logic [X_BITS-1:0]                 x_cnt;
  logic [Y_BITS-1:0]                 y_cnt;
  logic [X_BITS-1:0]                 cur_x;
  logic [Y_BITS-1:0]                 cur_y;

  logic                              pending;
  logic [NUM_REGIONS-1:0]            sh_enable;
  logic [NUM_REGIONS*X_BITS-1:0]     sh_x;
  logic [NUM_REGIONS*Y_BITS-1:0]     sh_y;
  logic [NUM_REGIONS*X_BITS-1:0]     sh_width;
  logic [NUM_REGIONS*Y_BITS-1:0]     sh_height;

  logic [NUM_REGIONS-1:0]            eff_enable;
  logic [NUM_REGIONS*X_BITS-1:0]     eff_x;
  logic [NUM_REGIONS*Y_BITS-1:0]     eff_y;
  logic [NUM_REGIONS*X_BITS-1:0]     eff_width;
  logic [NUM_REGIONS*Y_BITS-1:0]     eff_height;

  logic [NUM_REGIONS-1:0]            hit;
  logic [INDEX_BITS-1:0]             hit_index;
  logic [NUM_REGIONS*COUNT_BITS-1:0] cnt_all;
  logic [NUM_REGIONS*COUNT_BITS-1:0] cnt_next_all;

  assign frame_start = s_valid & s_row_first & s_col_first;
  assign frame_end   = s_valid & s_row_last  & s_col_last;

  // The shadow copy happens on the accepted frame-start pixel. A request
  // arriving in that same cycle is honoured directly, without waiting for
  // the pending flag to be set first.
  assign latch = cke & frame_start & (pending | update_req);

  // Coordinates are rebuilt from the markers so that a stray or missing
  // pixel only disturbs the rest of its own line or frame.
  always_comb begin
    cur_x = s_col_first ? '0 : x_cnt;
    if (frame_start) begin
      cur_y = '0;
    end else if (s_col_first) begin
      cur_y = y_cnt + Y_BITS'(1);
    end else begin
      cur_y = y_cnt;
    end
  end

  // While latching, the frame-start pixel is compared against the incoming
  // parameters instead of the stale shadows.
  assign eff_enable = latch ? param_enable : sh_enable;
  assign eff_x      = latch ? param_x      : sh_x;
  assign eff_y      = latch ? param_y      : sh_y;
  assign eff_width  = latch ? param_width  : sh_width;
  assign eff_height = latch ? param_height : sh_height;

  // Per-region hit test and next counter value. Rectangle end points are
  // formed one bit wider so a rectangle hanging past the coordinate range
  // never wraps around to low coordinates.
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    logic [X_BITS-1:0]   rx;
    logic [X_BITS-1:0]   rw;
    logic [Y_BITS-1:0]   ry;
    logic [Y_BITS-1:0]   rh;
    logic [X_BITS:0]     x_end;
    logic [Y_BITS:0]     y_end;
    logic [COUNT_BITS:0] cnt_sum;
    logic [COUNT_BITS-1:0] cnt_sat;

    assign rx    = eff_x[g*X_BITS +: X_BITS];
    assign rw    = eff_width[g*X_BITS +: X_BITS];
    assign ry    = eff_y[g*Y_BITS +: Y_BITS];
    assign rh    = eff_height[g*Y_BITS +: Y_BITS];
    assign x_end = {1'b0, rx} + {1'b0, rw};
    assign y_end = {1'b0, ry} + {1'b0, rh};

    assign hit[g] = eff_enable[g] & s_valid & s_de
                  & (cur_x >= rx) & ({1'b0, cur_x} < x_end)
                  & (cur_y >= ry) & ({1'b0, cur_y} < y_end);

    assign cnt_sum = {1'b0, cnt_all[g*COUNT_BITS +: COUNT_BITS]} + (COUNT_BITS+1)'(hit[g]);
    assign cnt_sat = cnt_sum[COUNT_BITS] ? '1 : cnt_sum[COUNT_BITS-1:0];
    assign cnt_next_all[g*COUNT_BITS +: COUNT_BITS] = frame_start ? COUNT_BITS'(hit[g]) : cnt_sat;
  end

  // Lowest-index hit wins: scan from the top so the lowest set bit is the
  // last one assigned.
  always_comb begin
    hit_index = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_index = INDEX_BITS'(i);
      end
    end
  end

  // Coordinate counters, update handshake and the parameter shadows. The
  // pending flag listens to update_req even while cke is low so a request is
  // never lost during a stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      pending    <= 1'b0;
      update_ack <= 1'b0;
      sh_enable  <= INIT_ENABLE;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_width   <= '0;
      sh_height  <= '0;
    end else begin
      update_ack <= latch;
      if (latch) begin
        pending   <= 1'b0;
        sh_enable <= param_enable;
        sh_x      <= param_x;
        sh_y      <= param_y;
        sh_width  <= param_width;
        sh_height <= param_height;
      end else if (update_req) begin
        pending <= 1'b1;
      end
      if (cke && s_valid) begin
        x_cnt <= cur_x + X_BITS'(1);
        y_cnt <= cur_y;
      end
    end
  end

  // One-stage output pipeline; holds its contents while cke is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_row_first <= 1'b0;
      m_row_last  <= 1'b0;
      m_col_first <= 1'b0;
      m_col_last  <= 1'b0;
      m_de        <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_mask      <= '0;
      m_hit       <= 1'b0;
      m_index     <= '0;
    end else if (cke) begin
      m_row_first <= s_row_first;
      m_row_last  <= s_row_last;
      m_col_first <= s_col_first;
      m_col_last  <= s_col_last;
      m_de        <= s_de;
      m_valid     <= s_valid;
      m_data      <= s_data;
      m_mask      <= hit;
      m_hit       <= |hit;
      m_index     <= hit_index;
    end
  end

  // Frame counters restart on every frame start, so a frame cut short by a
  // new frame start never reaches stat_count. The published value includes
  // the frame-end pixel itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_all    <= '0;
      stat_count <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= cke & frame_end;
      if (cke && s_valid) begin
        cnt_all <= cnt_next_all;
      end
      if (cke && frame_end) begin
        stat_count <= cnt_next_all;
      end
    end
  end

endmodule

// File: tb/tb_jelly3_img_region_multi_rect.sv
// ---------------------------------------------------------------------------
// Testbench for jelly3_img_region_multi_rect.
//
// Frames are driven as explicit (x, y) rasters with optional cke stalls,
// s_valid gaps and de holes. A reference model works from the frame
// coordinates and the rectangle rules directly (integer arithmetic, counts
// saturated once at frame end) and predicts every output after each clock.
// ---------------------------------------------------------------------------
module tb_jelly3_img_region_multi_rect;

  localparam int NR = 4;
  localparam int XB = 11;
  localparam int YB = 10;
  localparam int DB = 24;
  localparam int CB = 4;
  localparam int IB = 2;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic             clock;
  logic             reset;
  logic             cke;
  logic             update_req;
  logic             update_ack;
  logic [NR-1:0]    param_enable;
  logic [NR*XB-1:0] param_x;
  logic [NR*YB-1:0] param_y;
  logic [NR*XB-1:0] param_width;
  logic [NR*YB-1:0] param_height;
  logic             s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid;
  logic [DB-1:0]    s_data;
  logic             m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid;
  logic [DB-1:0]    m_data;
  logic [NR-1:0]    m_mask;
  logic             m_hit;
  logic [IB-1:0]    m_index;
  logic             stat_valid;
  logic [NR*CB-1:0] stat_count;

  jelly3_img_region_multi_rect #(
    .NUM_REGIONS (NR),
    .X_BITS      (XB),
    .Y_BITS      (YB),
    .DATA_BITS   (DB),
    .COUNT_BITS  (CB),
    .INDEX_BITS  (IB),
    .INIT_ENABLE ('0)
  ) dut (
    .reset        (reset),
    .clock        (clock),
    .cke          (cke),
    .update_req   (update_req),
    .update_ack   (update_ack),
    .param_enable (param_enable),
    .param_x      (param_x),
    .param_y      (param_y),
    .param_width  (param_width),
    .param_height (param_height),
    .s_row_first  (s_row_first),
    .s_row_last   (s_row_last),
    .s_col_first  (s_col_first),
    .s_col_last   (s_col_last),
    .s_de         (s_de),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .m_row_first  (m_row_first),
    .m_row_last   (m_row_last),
    .m_col_first  (m_col_first),
    .m_col_last   (m_col_last),
    .m_de         (m_de),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_mask       (m_mask),
    .m_hit        (m_hit),
    .m_index      (m_index),
    .stat_valid   (stat_valid),
    .stat_count   (stat_count)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Parameters requested by the bench, packed onto the DUT buses.
  int in_en[NR], in_x[NR], in_y[NR], in_w[NR], in_h[NR];

  always_comb begin
    param_enable = '0;
    param_x      = '0;
    param_y      = '0;
    param_width  = '0;
    param_height = '0;
    for (int i = 0; i < NR; i++) begin
      param_enable[i]          = in_en[i][0];
      param_x[i*XB +: XB]      = in_x[i][XB-1:0];
      param_y[i*YB +: YB]      = in_y[i][YB-1:0];
      param_width[i*XB +: XB]  = in_w[i][XB-1:0];
      param_height[i*YB +: YB] = in_h[i][YB-1:0];
    end
  end

  // Reference model state.
  int          act_en[NR], act_x[NR], act_y[NR], act_w[NR], act_h[NR];
  int          mdl_cnt[NR];
  bit          mdl_pend;
  logic [5:0]  exp_mark;
  logic [DB-1:0] exp_data;
  logic [NR-1:0] exp_mask;
  logic [IB-1:0] exp_idx;
  logic        exp_ack, exp_sv;
  logic [NR*CB-1:0] exp_stat;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("markers", 64'({m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid}), 64'(exp_mark));
    checkOutput("m_data", 64'(m_data), 64'(exp_data));
    checkOutput("m_mask", 64'(m_mask), 64'(exp_mask));
    checkOutput("m_hit", 64'(m_hit), 64'(|exp_mask));
    checkOutput("m_index", 64'(m_index), 64'(exp_idx));
    checkOutput("update_ack", 64'(update_ack), 64'(exp_ack));
    checkOutput("stat_valid", 64'(stat_valid), 64'(exp_sv));
    checkOutput("stat_count", 64'(stat_count), 64'(exp_stat));
  endtask

  task automatic modelReset();
    for (int i = 0; i < NR; i++) begin
      act_en[i] = 0; act_x[i] = 0; act_y[i] = 0; act_w[i] = 0; act_h[i] = 0;
      mdl_cnt[i] = 0;
    end
    mdl_pend = 0;
    exp_mark = '0; exp_data = '0; exp_mask = '0; exp_idx = '0;
    exp_ack = 0; exp_sv = 0; exp_stat = '0;
  endtask

  // Predicts the effect of one clock edge for a pixel at frame position (x, y).
  task automatic modelEdge(input int x, input int y);
    bit fs, fe, latch;
    logic [NR-1:0] mask;
    fs = s_valid & s_row_first & s_col_first;
    fe = s_valid & s_row_last & s_col_last;
    latch = cke & fs & (mdl_pend | update_req);
    mdl_pend = latch ? 1'b0 : (mdl_pend | update_req);
    if (latch) begin
      for (int i = 0; i < NR; i++) begin
        act_en[i] = in_en[i]; act_x[i] = in_x[i]; act_y[i] = in_y[i];
        act_w[i] = in_w[i]; act_h[i] = in_h[i];
      end
    end
    exp_ack = latch;
    exp_sv  = 0;
    if (cke) begin
      mask = '0;
      for (int i = 0; i < NR; i++) begin
        if (act_en[i] != 0 && s_valid && s_de &&
            x >= act_x[i] && x < act_x[i] + act_w[i] &&
            y >= act_y[i] && y < act_y[i] + act_h[i])
          mask[i] = 1'b1;
      end
      exp_mark = {s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid};
      exp_data = s_data;
      exp_mask = mask;
      exp_idx  = '0;
      for (int i = NR - 1; i >= 0; i--) if (mask[i]) exp_idx = IB'(i);
      if (s_valid) begin
        for (int i = 0; i < NR; i++) begin
          if (fs) mdl_cnt[i] = 0;
          mdl_cnt[i] += int'(mask[i]);
        end
        if (fe) begin
          for (int i = 0; i < NR; i++)
            exp_stat[i*CB +: CB] = CB'((mdl_cnt[i] > CNT_MAX) ? CNT_MAX : mdl_cnt[i]);
          exp_sv = 1;
        end
      end
    end
  endtask

  // Presents one input beat (pixel or gap) and holds it until accepted by a
  // cke-high edge; update_req is raised for the first clock only.
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input bit valid, input bit de, input bit req, input int stall_pct);
    int stalls;
    bit first;
    bit done;
    stalls = 0; first = 1; done = 0;
    s_valid     = valid;
    s_de        = valid & de;
    s_col_first = valid && (x == 0);
    s_row_first = valid && (y == 0);
    s_col_last  = valid && (x == w - 1);
    s_row_last  = valid && (y == h - 1);
    s_data      = DB'($urandom);
    while (!done) begin
      cke = (stalls < 50 && $urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      update_req = req & first;
      @(posedge clock);
      modelEdge(x, y);
      #1;
      compareAll();
      if (cke) done = 1; else stalls++;
      first = 0;
    end
    update_req = 1'b0;
  endtask

  task automatic idle(input int n, input bit req);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 1, 0, 0, req && i == 0, 0);
  endtask

  task automatic runFrame(input int w, input int h, input int stall_pct, input int gap_pct,
                          input int de_pct, input int req_at, input int stop_after);
    int n;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (stop_after >= 0 && n >= stop_after) return;
        if ($urandom_range(99) < gap_pct) applyStimulus(0, 0, w, h, 0, 0, 0, stall_pct);
        applyStimulus(x, y, w, h, 1, $urandom_range(99) >= de_pct, n == req_at, stall_pct);
        n++;
      end
    end
  endtask

  task automatic setRegion(input int i, input int en, input int x, input int y, input int w, input int h);
    in_en[i] = en; in_x[i] = x; in_y[i] = y; in_w[i] = w; in_h[i] = h;
  endtask

  task automatic clearRegions();
    for (int i = 0; i < NR; i++) setRegion(i, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clearRegions();
    reset = 1'b1; cke = 1'b0; update_req = 1'b0;
    s_row_first = 0; s_row_last = 0; s_col_first = 0; s_col_last = 0;
    s_de = 0; s_valid = 0; s_data = '0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    compareAll();
    reset = 1'b0;
    idle(2, 0);

    // Single rectangle at (2..4, 1..2) on an 8x4 frame.
    setRegion(0, 1, 2, 1, 3, 2);
    idle(1, 1);
    idle(1, 0);
    runFrame(8, 4, 0, 0, 0, -1, -1);
    checkOutput("t1_count0", 64'(stat_count[0 +: CB]), 64'd6);
    idle(2, 0);

    // Overlapping rectangles, request on the frame-start pixel.
    clearRegions();
    setRegion(1, 1, 0, 0, 8, 4);
    setRegion(3, 1, 4, 2, 1, 1);
    runFrame(8, 4, 0, 0, 0, 0, -1);
    checkOutput("t2_count1_sat", 64'(stat_count[1*CB +: CB]), 64'd15);
    checkOutput("t2_count3", 64'(stat_count[3*CB +: CB]), 64'd1);
    idle(2, 0);

    // Mid-frame request only takes effect at the next frame start.
    setRegion(1, 1, 0, 0, 2, 2);
    runFrame(8, 4, 0, 0, 0, 10, -1);
    checkOutput("t3_old_params", 64'(stat_count[1*CB +: CB]), 64'd15);
    runFrame(8, 4, 0, 0, 0, -1, -1);
    checkOutput("t3_new_params", 64'(stat_count[1*CB +: CB]), 64'd4);
    idle(2, 0);

    // Randomised regions, stalls, gaps and de holes.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NR; i++)
        setRegion(i, $urandom_range(1), $urandom_range(12), $urandom_range(7),
                  $urandom_range(8), $urandom_range(5));
      runFrame($urandom_range(12, 2), $urandom_range(6, 2), 30, 20, 10,
               ($urandom_range(3) == 0) ? -1 : $urandom_range(5), -1);
      idle($urandom_range(3), $urandom_range(1));
    end
    idle(2, 0);

    // Rectangle at the right edge of the coordinate range, zero sizes.
    clearRegions();
    setRegion(0, 1, 2040, 0, 100, 2);
    setRegion(1, 1, 0, 0, 0, 2);
    setRegion(2, 1, 0, 0, 5, 0);
    idle(1, 1);
    runFrame(2048, 2, 0, 0, 0, -1, -1);
    checkOutput("t5_edge_count", 64'(stat_count[0 +: CB]), 64'd15);
    checkOutput("t5_zero_w", 64'(stat_count[1*CB +: CB]), 64'd0);
    checkOutput("t5_zero_h", 64'(stat_count[2*CB +: CB]), 64'd0);
    idle(2, 0);

    // Reset in the middle of a frame, then a clean frame.
    clearRegions();
    setRegion(2, 1, 1, 1, 3, 2);
    idle(1, 1);
    runFrame(8, 4, 0, 0, 0, -1, 13);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(posedge clock);
    #2;
    reset = 1'b0;
    idle(1, 1);
    runFrame(8, 4, 10, 10, 0, -1, -1);
    checkOutput("t6_after_reset", 64'(stat_count[2*CB +: CB]), 64'd6);
    idle(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
